// File: rtl/serial_tx.sv
// serial_tx: parallel-to-serial frame transmitter (start, DATA_W bits LSB first, optional parity, stop).
// Ports: CLK, RST (async active-low), DATA_IN/VALID/READY accept handshake, OUT serial line, BUSY = ~READY.
module serial_tx #(
  parameter int DATA_W = 8,
  parameter int DIV    = 4,
  parameter int PARITY = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic              VALID,
  output logic              READY,
  output logic              OUT,
  output logic              BUSY
);

  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [7:0] CNT_LD = 8'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);
  localparam logic ODD = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              out_q, out_d;
  logic              ready_q, ready_d;

  logic          tick;
  logic          par_bit;
  logic [IW-1:0] idx_nx;

  assign tick    = (cnt_q == 8'd0);
  assign par_bit = (^shift_q) ^ ODD;
  assign idx_nx  = idx_q + IW'(1);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      out_q   <= 1'b1;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      out_q   <= out_d;
      ready_q <= ready_d;
    end
  end

  // Each transition loads the level of the upcoming bit into out_q,
  // so OUT changes on the same edge the state changes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    out_d   = out_q;
    ready_d = ready_q;
    unique case (state_q)
      S_IDLE: begin
        if (VALID && ready_q) begin
          state_d = S_START;
          shift_d = DATA_IN;
          cnt_d   = CNT_LD;
          idx_d   = '0;
          out_d   = 1'b0;
          ready_d = 1'b0;
        end
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          cnt_d   = CNT_LD;
          idx_d   = '0;
          out_d   = shift_q[0];
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_DATA: begin
        if (tick) begin
          cnt_d = CNT_LD;
          if (idx_q == IDX_LAST) begin
            if (PARITY != 0) begin
              state_d = S_PAR;
              out_d   = par_bit;
            end else begin
              state_d = S_STOP;
              out_d   = 1'b1;
            end
          end else begin
            idx_d = idx_nx;
            out_d = shift_q[idx_nx];
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_PAR: begin
        if (tick) begin
          state_d = S_STOP;
          cnt_d   = CNT_LD;
          out_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_STOP: begin
        if (tick) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
          out_d   = 1'b1;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
        out_d   = 1'b1;
        ready_d = 1'b1;
      end
    endcase
  end

  assign OUT   = out_q;
  assign READY = ready_q;
  assign BUSY  = ~ready_q;

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: four serial_tx configs checked every cycle against a frame-level model.
// Configs: 0 DIV=4 no parity, 1 even, 2 odd, 3 DIV=1 no parity.
module tb_serial_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] vld;
  logic [3:0] rdy;
  logic [3:0] outs;
  logic [3:0] busy;
  logic [7:0] din [4];

  int         rem [4];
  logic [7:0] dl  [4];
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : gi
    serial_tx #(
      .DATA_W(8),
      .DIV((g == 3) ? 1 : 4),
      .PARITY((g == 1) ? 1 : ((g == 2) ? 2 : 0))
    ) u_dut (
      .CLK(clk),
      .RST(rst),
      .DATA_IN(din[g]),
      .VALID(vld[g]),
      .READY(rdy[g]),
      .OUT(outs[g]),
      .BUSY(busy[g])
    );
  end

  function automatic int divof(input int g);
    return (g == 3) ? 1 : 4;
  endfunction

  function automatic int parof(input int g);
    return (g == 1) ? 1 : ((g == 2) ? 2 : 0);
  endfunction

  function automatic int nbof(input int g);
    return (parof(g) != 0) ? 11 : 10;
  endfunction

  // Level of frame bit k: start, 8 data LSB first, optional parity, stop.
  function automatic logic expbit(input int p, input logic [7:0] d,
                                  input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (k == 9 && p != 0) return (^d) ^ (p == 2);
    return 1'b1;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0b, want %0b", nm, act, req);
    end
  endtask

  task automatic chki(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, req);
    end
  endtask

  // Model: rem = cycles left in the current frame, 0 means idle.
  always @(posedge clk or negedge rst) begin
    for (int g = 0; g < 4; g++) begin
      if (!rst) begin
        rem[g] <= 0;
      end else if (rem[g] > 0) begin
        rem[g] <= rem[g] - 1;
      end else if (vld[g]) begin
        dl[g]  <= din[g];
        rem[g] <= nbof(g) * divof(g);
      end
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < 4; g++) begin
      int   k;
      logic eo;
      k  = (nbof(g) * divof(g) - rem[g]) / divof(g);
      eo = (rem[g] == 0) ? 1'b1 : expbit(parof(g), dl[g], k);
      chk1($sformatf("out%0d", g), outs[g], eo);
      chk1($sformatf("ready%0d", g), rdy[g], rem[g] == 0);
      chk1($sformatf("busy%0d", g), busy[g], rem[g] != 0);
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (rdy != 4'hF && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (rdy != 4'hF) chki("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  // Send one word on instance g, sample mid-bit levels against a literal.
  task automatic send_lit(input int g, input logic [7:0] d,
                          input logic [10:0] ex, input int nb);
    int dv;
    int bc;
    dv = divof(g);
    bc = 0;
    din[g] = d;
    vld[g] = 1'b1;
    @(posedge clk);
    #1;
    vld[g] = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (rdy[g]) break;
      bc++;
      if (c % dv == 0 && c / dv < nb)
        chk1($sformatf("lit%0d_bit%0d", g, c / dv), outs[g], ex[c / dv]);
    end
    chki($sformatf("lit%0d_len", g), bc, nb * dv);
  endtask

  initial begin
    int         cnt;
    logic [10:0] pin;
    vld = '0;
    for (int g = 0; g < 4; g++) din[g] = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    chk1("rst_out", outs[0], 1'b1);
    chk1("rst_ready", rdy[0], 1'b1);
    chk1("rst_busy", busy[0], 1'b0);
    rst = 1'b1;

    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (outs != 4'hF) cnt++;
    end
    chki("idle100", cnt, 0);

    pin = 11'b10101001010;
    for (int k = 0; k < 11; k++)
      chk1("model_pin_even", expbit(1, 8'hA5, k), pin[k]);
    pin = 11'b10000000010;
    for (int k = 0; k < 11; k++)
      chk1("model_pin_odd", expbit(2, 8'h01, k), pin[k]);

    wait_idle();
    send_lit(0, 8'hA5, 11'b01101001010, 10);
    wait_idle();
    send_lit(1, 8'hA5, 11'b10101001010, 11);
    wait_idle();
    send_lit(2, 8'hA5, 11'b11101001010, 11);
    wait_idle();
    send_lit(1, 8'h01, 11'b11000000010, 11);
    wait_idle();
    send_lit(2, 8'h01, 11'b10000000010, 11);
    wait_idle();
    send_lit(3, 8'h81, 11'b01100000010, 10);

    wait_idle();
    din[0] = 8'h00;
    vld[0] = 1'b1;
    @(posedge clk);
    #1;
    din[0] = 8'hFF;
    begin
      int  idle;
      bit  seen;
      idle = 0;
      seen = 1'b0;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if (rdy[0]) begin
          idle++;
          seen = 1'b1;
          chk1("b2b_gap_out", outs[0], 1'b1);
        end else if (seen) begin
          break;
        end
      end
      vld[0] = 1'b0;
      chki("b2b_idle", idle, 1);
    end

    wait_idle();
    cnt = 0;
    for (int c = 0; c < 70; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) begin din[0] = 8'h5A; vld[0] = 1'b1; end
      if (c == 1) vld[0] = 1'b0;
      if (c == 12) begin din[0] = 8'hC3; vld[0] = 1'b1; end
      if (c == 13) begin vld[0] = 1'b0; din[0] = 8'h00; end
      @(negedge clk);
      if (busy[0]) cnt++;
    end
    chki("ignore_busy_len", cnt, 40);

    wait_idle();
    din[0] = 8'h96;
    vld[0] = 1'b1;
    @(posedge clk);
    #1;
    vld[0] = 1'b0;
    repeat (17) @(posedge clk);
    #3;
    chk1("mid_bit3", outs[0], 1'b0);
    rst = 1'b0;
    #1;
    chk1("async_out", outs[0], 1'b1);
    chk1("async_ready", rdy[0], 1'b1);
    chk1("async_busy", busy[0], 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    send_lit(0, 8'h3C, 11'b01001111000, 10);

    wait_idle();
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 399) == 0) rst = 1'b0;
      for (int g = 0; g < 4; g++) begin
        vld[g] = ($urandom_range(0, 3) != 0);
        din[g] = 8'($urandom);
      end
    end
    vld = '0;
    rst = 1'b1;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
